// File: rtl/alu_bus_pkg.sv
// Shared definitions for the 4-bit ADDI coprocessor bus (host and coprocessor sides).
package alu_bus_pkg;

  localparam int unsigned DW = 4;

  localparam logic [DW-1:0] OP_NOP  = 4'd0;
  localparam logic [DW-1:0] OP_ADDI = 4'd1;

  localparam logic [DW-1:0] BREQ_OPERAND = 4'b0011;
  localparam logic [DW-1:0] BREQ_VALUE   = 4'b0001;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    REQ,
    DRIVE,
    WAIT
  } host_state_e;

endpackage

// File: rtl/alu_host_regfile.sv
// Host-local register file: one write port (write-back beats preload), two async read ports.
module alu_host_regfile
  import alu_bus_pkg::*;
#(
  parameter int unsigned NREGS = 4,
  parameter int unsigned RW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_we_i,
  input  logic [RW-1:0] wb_addr_i,
  input  logic [DW-1:0] wb_data_i,
  input  logic          pl_we_i,
  input  logic [RW-1:0] pl_addr_i,
  input  logic [DW-1:0] pl_data_i,
  input  logic [RW-1:0] rs_addr_i,
  output logic [DW-1:0] rs_data_c_o,
  input  logic [RW-1:0] dbg_addr_i,
  output logic [DW-1:0] dbg_data_c_o
);

  logic [DW-1:0] mem_q [NREGS];

  // Storage update; a write-back in the same cycle as a preload takes the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wb_we_i) begin
      mem_q[wb_addr_i] <= wb_data_i;
    end else if (pl_we_i) begin
      mem_q[pl_addr_i] <= pl_data_i;
    end
  end

  assign rs_data_c_o  = mem_q[rs_addr_i];
  assign dbg_data_c_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_host_seq.sv
// Host-side sequencer: issues ADDI to the coprocessor, serves its operand request, writes back the sum.
module alu_host_seq
  import alu_bus_pkg::*;
#(
  parameter int unsigned NREGS   = 4,
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned RW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_imm,
  input  logic [RW-1:0] cmd_rs,
  input  logic [RW-1:0] cmd_rd,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_sum,
  output logic          rsp_carry,
  output logic          rsp_err,
  input  logic          rf_we,
  input  logic [RW-1:0] rf_waddr,
  input  logic [DW-1:0] rf_wdata,
  input  logic [RW-1:0] rf_raddr,
  output logic [DW-1:0] rf_rdata,
  output logic [DW-1:0] cp_opcode,
  output logic [DW-1:0] cp_imm,
  input  logic [DW-1:0] cp_bus_req,
  input  logic [DW-1:0] cp_bus_in,
  output logic [DW-1:0] cp_bus_out,
  output logic          cp_bus_oe,
  input  logic          cp_done,
  input  logic          cp_carry
);

  localparam int unsigned CW = 4;

  host_state_e   state_q, state_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] rs_q, rs_d, rd_q, rd_d;
  logic [DW-1:0] opcode_q, opcode_d, imm_q, imm_d;
  logic [DW-1:0] bus_out_q, bus_out_d;
  logic          bus_oe_q, bus_oe_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic          rsp_carry_q, rsp_carry_d;
  logic [DW-1:0] rsp_sum_q, rsp_sum_d;
  logic          wb_we_c, abort_c, tmo_hit_c, pl_we_c;
  logic [DW-1:0] rs_data_c;

  assign tmo_hit_c = (tmo_q == CW'(TIMEOUT - 1));
  assign pl_we_c   = rf_we && (state_q == IDLE);

  alu_host_regfile #(
    .NREGS(NREGS),
    .RW   (RW)
  ) u_rf (
    .clk         (clk),
    .rst         (rst),
    .wb_we_i     (wb_we_c),
    .wb_addr_i   (rd_q),
    .wb_data_i   (cp_bus_in),
    .pl_we_i     (pl_we_c),
    .pl_addr_i   (rf_waddr),
    .pl_data_i   (rf_wdata),
    .rs_addr_i   (rs_q),
    .rs_data_c_o (rs_data_c),
    .dbg_addr_i  (rf_raddr),
    .dbg_data_c_o(rf_rdata)
  );

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      rs_q        <= '0;
      rd_q        <= '0;
      opcode_q    <= OP_NOP;
      imm_q       <= '0;
      bus_out_q   <= '0;
      bus_oe_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_carry_q <= 1'b0;
      rsp_sum_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      rs_q        <= rs_d;
      rd_q        <= rd_d;
      opcode_q    <= opcode_d;
      imm_q       <= imm_d;
      bus_out_q   <= bus_out_d;
      bus_oe_q    <= bus_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_sum_q   <= rsp_sum_d;
    end
  end

  // Next-state, handshake progress and timeout abort.
  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    rs_d        = rs_q;
    rd_d        = rd_q;
    opcode_d    = opcode_q;
    imm_d       = imm_q;
    bus_out_d   = bus_out_q;
    bus_oe_d    = bus_oe_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_carry_d = rsp_carry_q;
    rsp_sum_d   = rsp_sum_q;
    wb_we_c     = 1'b0;
    abort_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          rs_d     = cmd_rs;
          rd_d     = cmd_rd;
          imm_d    = cmd_imm;
          opcode_d = OP_ADDI;
          state_d  = ARM;
        end
      end
      ARM: begin
        if (!cp_done) state_d = REQ;
        else if (tmo_hit_c) abort_c = 1'b1;
      end
      REQ: begin
        if (cp_bus_req == BREQ_OPERAND) begin
          bus_out_d = rs_data_c;
          bus_oe_d  = 1'b1;
          state_d   = DRIVE;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      DRIVE: begin
        if (cp_bus_req == BREQ_VALUE) begin
          bus_oe_d = 1'b0;
          state_d  = WAIT;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      WAIT: begin
        if (cp_done) begin
          rsp_sum_d   = cp_bus_in;
          rsp_carry_d = cp_carry;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          wb_we_c     = 1'b1;
          opcode_d    = OP_NOP;
          state_d     = IDLE;
        end else if (tmo_hit_c) begin
          abort_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (abort_c) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      bus_oe_d    = 1'b0;
      opcode_d    = OP_NOP;
      state_d     = IDLE;
    end

    if (state_d != state_q) tmo_d = '0;
    else if (state_q != IDLE) tmo_d = tmo_q + CW'(1);
  end

  assign cmd_ready  = (state_q == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_sum    = rsp_sum_q;
  assign rsp_carry  = rsp_carry_q;
  assign rsp_err    = rsp_err_q;
  assign cp_opcode  = opcode_q;
  assign cp_imm     = imm_q;
  assign cp_bus_out = bus_out_q;
  assign cp_bus_oe  = bus_oe_q;

endmodule

// File: tb/tb_alu_host_seq.sv
// Directed bench for alu_host_seq with a phase-accurate coprocessor model.
module tb_alu_host_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready;
  logic [3:0] cmd_imm;
  logic [1:0] cmd_rs, cmd_rd;
  logic       rsp_valid, rsp_carry, rsp_err;
  logic [3:0] rsp_sum;
  logic       rf_we;
  logic [1:0] rf_waddr, rf_raddr;
  logic [3:0] rf_wdata, rf_rdata;
  logic [3:0] cp_opcode, cp_imm, cp_bus_out;
  logic       cp_bus_oe;
  logic [3:0] m_req, m_bus, m_opnd;
  logic       m_done, m_carry, m_oe;
  logic       no_done;

  int vectors = 0;
  int errs    = 0;
  int lat;
  logic [3:0] rv;

  typedef enum {C_IDLE, C_PH0, C_PH1, C_PH2, C_PH3, C_DONE, C_REL} cst_e;
  cst_e cst;

  always #5 clk = ~clk;

  alu_host_seq dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_imm   (cmd_imm),
    .cmd_rs    (cmd_rs),
    .cmd_rd    (cmd_rd),
    .rsp_valid (rsp_valid),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .cp_opcode (cp_opcode),
    .cp_imm    (cp_imm),
    .cp_bus_req(m_req),
    .cp_bus_in (m_bus),
    .cp_bus_out(cp_bus_out),
    .cp_bus_oe (cp_bus_oe),
    .cp_done   (m_done),
    .cp_carry  (m_carry)
  );

  // Coprocessor: phase0 drops done, phase1 requests operand, phase2 samples bus, then computes.
  // After done, done is held one extra cycle once opcode returns to NOP.
  always @(posedge clk) begin
    if (rst) begin
      cst <= C_IDLE; m_done <= 1'b0; m_req <= 4'd0; m_bus <= 4'd0;
      m_carry <= 1'b0; m_opnd <= 4'd0; m_oe <= 1'b0;
    end else begin
      case (cst)
        C_IDLE: if (cp_opcode == 4'd1) begin m_done <= 1'b0; m_req <= 4'd0; cst <= C_PH0; end
        C_PH0:  begin m_req <= 4'b0011; cst <= C_PH1; end
        C_PH1:  begin m_req <= 4'b0001; cst <= C_PH2; end
        C_PH2:  begin m_opnd <= cp_bus_out; m_oe <= cp_bus_oe; m_req <= 4'd0; cst <= C_PH3; end
        C_PH3:  begin
          {m_carry, m_bus} <= 5'(m_opnd) + 5'(cp_imm);
          m_done <= ~no_done;
          cst <= C_DONE;
        end
        C_DONE: if (cp_opcode == 4'd0) cst <= C_REL;
        default: begin m_done <= 1'b0; cst <= C_IDLE; end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic peek(input logic [1:0] a, output logic [3:0] v);
    rf_raddr = a;
    #1;
    v = rf_rdata;
  endtask

  task automatic preload(input logic [1:0] a, input logic [3:0] d);
    @(negedge clk);
    rf_we = 1'b1; rf_waddr = a; rf_wdata = d;
    @(posedge clk);
    #1 rf_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] imm, input logic [1:0] rs, input logic [1:0] rd,
                       input logic pwe, input logic [1:0] pa, input logic [3:0] pd);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_imm = imm; cmd_rs = rs; cmd_rd = rd;
    rf_we = pwe; rf_waddr = pa; rf_wdata = pd;
    @(posedge clk);
    #1 cmd_valid = 1'b0; rf_we = 1'b0;
  endtask

  task automatic wait_rsp(input int start, output int l);
    logic got;
    got = 1'b0;
    l = start;
    while (!got && l < 40) begin
      @(posedge clk);
      #1 l++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", 8'(got), 8'd1);
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_imm = 4'd0; cmd_rs = 2'd0; cmd_rd = 2'd0;
    rf_we = 1'b0; rf_waddr = 2'd0; rf_wdata = 4'd0; rf_raddr = 2'd0; no_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 8'(cmd_ready), 8'd1);
    chk("rst_valid", 8'(rsp_valid), 8'd0);
    chk("rst_opcode", 8'(cp_opcode), 8'd0);
    chk("rst_imm", 8'(cp_imm), 8'd0);
    chk("rst_oe", 8'(cp_bus_oe), 8'd0);
    chk("rst_busout", 8'(cp_bus_out), 8'd0);
    chk("rst_sum", 8'({rsp_err, rsp_carry, rsp_sum}), 8'd0);
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), rv);
      chk("rst_rf", 8'(rv), 8'd0);
    end
    rst = 1'b0;

    // r2=5, 3+5 -> r1=8
    preload(2'd2, 4'h5);
    peek(2'd2, rv);
    chk("preload_r2", 8'(rv), 8'h5);
    issue(4'h3, 2'd2, 2'd1, 1'b0, 2'd0, 4'd0);
    chk("busy_ready", 8'(cmd_ready), 8'd0);
    chk("opcode_addi", 8'(cp_opcode), 8'd1);
    chk("imm_drive", 8'(cp_imm), 8'h3);
    wait_rsp(0, lat);
    chk("t1_latency", 8'(lat), 8'd6);
    chk("t1_sum", 8'(rsp_sum), 8'h8);
    chk("t1_carry", 8'(rsp_carry), 8'd0);
    chk("t1_err", 8'(rsp_err), 8'd0);
    chk("t1_opcode", 8'(cp_opcode), 8'd0);
    chk("t1_oe", 8'(cp_bus_oe), 8'd0);
    chk("t1_operand", 8'(m_opnd), 8'h5);
    chk("t1_operand_oe", 8'(m_oe), 8'd1);
    peek(2'd1, rv);
    chk("t1_rf1", 8'(rv), 8'h8);
    @(posedge clk);
    #1 chk("t1_pulse", 8'(rsp_valid), 8'd0);
    repeat (4) @(posedge clk);

    // r0=F, rs==rd, 2+F -> sum 1 carry 1; then back-to-back r3=7 + 1
    preload(2'd0, 4'hF);
    preload(2'd3, 4'h7);
    issue(4'h2, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
    wait_rsp(0, lat);
    chk("t2_latency", 8'(lat), 8'd6);
    chk("t2_sum", 8'(rsp_sum), 8'h1);
    chk("t2_carry", 8'(rsp_carry), 8'd1);
    peek(2'd0, rv);
    chk("t2_rf0", 8'(rv), 8'h1);
    issue(4'h1, 2'd3, 2'd2, 1'b0, 2'd0, 4'd0);
    wait_rsp(0, lat);
    chk("b2b_latency", 8'(lat), 8'd7);
    chk("b2b_sum", 8'(rsp_sum), 8'h8);
    chk("b2b_carry", 8'(rsp_carry), 8'd0);
    peek(2'd2, rv);
    chk("b2b_rf2", 8'(rv), 8'h8);
    repeat (4) @(posedge clk);

    // done never arrives: abort after the wait budget; preload during WAIT ignored
    no_done = 1'b1;
    issue(4'h1, 2'd1, 2'd3, 1'b0, 2'd0, 4'd0);
    repeat (6) @(posedge clk);
    #1 rf_we = 1'b1; rf_waddr = 2'd1; rf_wdata = 4'hA;
    @(posedge clk);
    #1 rf_we = 1'b0;
    wait_rsp(7, lat);
    chk("tmo_latency", 8'(lat), 8'd19);
    chk("tmo_err", 8'(rsp_err), 8'd1);
    chk("tmo_sum_kept", 8'(rsp_sum), 8'h8);
    chk("tmo_carry_kept", 8'(rsp_carry), 8'd0);
    chk("tmo_oe", 8'(cp_bus_oe), 8'd0);
    chk("tmo_opcode", 8'(cp_opcode), 8'd0);
    chk("tmo_ready", 8'(cmd_ready), 8'd1);
    peek(2'd3, rv);
    chk("tmo_rf3", 8'(rv), 8'h7);
    peek(2'd1, rv);
    chk("wait_preload_ignored", 8'(rv), 8'h8);
    no_done = 1'b0;
    repeat (4) @(posedge clk);

    // preload and command together, rs == preload address: operand is the new value
    issue(4'h4, 2'd1, 2'd3, 1'b1, 2'd1, 4'h9);
    wait_rsp(0, lat);
    chk("t6_sum", 8'(rsp_sum), 8'hD);
    chk("t6_carry", 8'(rsp_carry), 8'd0);
    chk("t6_err", 8'(rsp_err), 8'd0);
    peek(2'd3, rv);
    chk("t6_rf3", 8'(rv), 8'hD);
    repeat (4) @(posedge clk);

    // reset while driving the bus
    issue(4'h1, 2'd0, 2'd0, 1'b0, 2'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1 chk("drive_oe", 8'(cp_bus_oe), 8'd1);
    chk("drive_value", 8'(cp_bus_out), 8'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_oe", 8'(cp_bus_oe), 8'd0);
    chk("rst_mid_opcode", 8'(cp_opcode), 8'd0);
    chk("rst_mid_ready", 8'(cmd_ready), 8'd1);
    for (int i = 0; i < 4; i++) begin
      peek(2'(i), rv);
      chk("rst_mid_rf", 8'(rv), 8'd0);
    end
    rst = 1'b0;

    // normal operation resumes after the abort
    preload(2'd2, 4'h5);
    issue(4'h3, 2'd2, 2'd1, 1'b0, 2'd0, 4'd0);
    wait_rsp(0, lat);
    chk("post_latency", 8'(lat), 8'd6);
    chk("post_sum", 8'(rsp_sum), 8'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
